// File: rtl/data_ram_resp_if.sv
// Request/response bus between the memory-access stage and data_ram_resp.
// Optional feature macro: DMEM_ERR_EN adds the err_o range-error flag.
interface data_ram_resp_if;
    logic        ce_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [3:0]  sel_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        stall_o;
    logic        ack_o;
`ifdef DMEM_ERR_EN
    logic        err_o;

    modport master (
        output ce_i, we_i, addr_i, sel_i, data_i,
        input  data_o, stall_o, ack_o, err_o
    );
    modport slave (
        input  ce_i, we_i, addr_i, sel_i, data_i,
        output data_o, stall_o, ack_o, err_o
    );
`else
    modport master (
        output ce_i, we_i, addr_i, sel_i, data_i,
        input  data_o, stall_o, ack_o
    );
    modport slave (
        input  ce_i, we_i, addr_i, sel_i, data_i,
        output data_o, stall_o, ack_o
    );
`endif
endinterface

// File: rtl/data_ram_resp.sv
// Word-organised data RAM with a wait-stated IDLE/BUSY/DONE request handshake.
// Big-endian byte lanes: sel_i[3] covers bits 31:24 (byte offset 0).
// Optional feature macro: DMEM_ERR_EN adds out-of-range detection and err_o;
// without it, address bits above the word index wrap modulo the depth.
module data_ram_resp #(
    parameter int unsigned DEPTH_LOG2  = 10,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic             clk,
    input  logic             rst,
    data_ram_resp_if.slave   bus
);

    localparam int unsigned DEPTH = 2 ** DEPTH_LOG2;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [3:0]              r_cnt;
    logic                    r_we;
    logic [DEPTH_LOG2-1:0]   r_idx;
    logic [3:0]              r_sel;
    logic [31:0]             r_wdata;
    logic [31:0]             r_dout;
    logic [31:0]             r_mem [DEPTH];
    logic                    w_stall;
    logic                    w_ack;
    logic                    w_accept;
    logic                    w_access;
    logic                    w_oob;
    logic [31:0]             w_mask;
    logic                    w_unused;

    assign w_accept = (r_state == StIdle) && bus.ce_i;
    assign w_access = (r_state == StBusy) && (r_cnt == 4'd0);
    assign w_mask   = {{8{r_sel[3]}}, {8{r_sel[2]}}, {8{r_sel[1]}}, {8{r_sel[0]}}};

    // Byte offset bits never matter; upper bits only matter for the range check.
    assign w_unused = ^{bus.addr_i[1:0], bus.addr_i >> (DEPTH_LOG2 + 2)};

`ifdef DMEM_ERR_EN
    logic r_oob;
    logic r_err;

    // Range flag is captured with the request so BUSY-time address changes are ignored.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_oob <= (bus.addr_i >> (DEPTH_LOG2 + 2)) != 32'd0;
        end
    end

    // err_o is high only in the DONE cycle of an out-of-range request.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_access && r_oob;
        end
    end

    assign w_oob     = r_oob;
    assign bus.err_o = r_err;
`else
    assign w_oob = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic plus stall/ack decode.
    always_comb begin
        w_state_next = r_state;
        w_stall      = 1'b0;
        w_ack        = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_stall = bus.ce_i;
                if (bus.ce_i) begin
                    w_state_next = StBusy;
                end
            end
            StBusy: begin
                w_stall = 1'b1;
                if (r_cnt == 4'd0) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                w_ack        = 1'b1;
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // Wait-state counter: loaded on acceptance, counts down while BUSY.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 4'd0;
        end else if (w_accept) begin
            r_cnt <= 4'(WAIT_CYCLES);
        end else if ((r_state == StBusy) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Request capture; fields are frozen for the whole BUSY period.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_we    <= bus.we_i;
            r_idx   <= bus.addr_i[DEPTH_LOG2+1:2];
            r_sel   <= bus.sel_i;
            r_wdata <= bus.data_i;
        end
    end

    // Storage write; reset aborts a pending write and never clears contents.
    always_ff @(posedge clk) begin
        if (!rst && w_access && r_we && !w_oob) begin
            for (int b = 0; b < 4; b++) begin
                if (r_sel[b]) begin
                    r_mem[r_idx][8*b +: 8] <= r_wdata[8*b +: 8];
                end
            end
        end
    end

    // Read data register; only read completions update it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout <= 32'd0;
        end else if (w_access && !r_we) begin
            r_dout <= w_oob ? 32'd0 : (r_mem[r_idx] & w_mask);
        end
    end

    assign bus.data_o  = r_dout;
    assign bus.stall_o = w_stall;
    assign bus.ack_o   = w_ack;

endmodule
